usb_otg_rst_seq: RTL and testbench



---
 rtl/usb_otg_rst_seq_pkg.sv | 28 ++
 rtl/usb_otg_rst_seq_if.sv | 14 +
 rtl/usb_otg_rst_seq.sv | 148 ++++++++++++++
 tb/tb_usb_otg_rst_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_otg_rst_seq_pkg.sv
// Shared types and constants for the USB OTG reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, Avalon status-slave word addresses, and the
// bit positions of the fields in the status word.
package usb_otg_rst_pkg;

  // The encoding is software-visible through the status word, so it is fixed.
  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_TIMER  = 2'd2;

  localparam int STAT_READY_BIT = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_STATE_MSB = 2;
  localparam int STAT_RQ_BIT    = 3;
  localparam int STAT_IRQ_BIT   = 4;

  localparam logic [15:0] RST_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/usb_otg_rst_seq_if.sv
// Avalon-MM read-only status slave bundle for the USB OTG reset sequencer.
// Latency: readdata returns one clk after the read strobe.
// Backpressure: none; the slave always accepts reads (no waitrequest).
//
// Signals: avs_address (word address), avs_read (strobe),
//          avs_readdata (registered read data).
interface usb_otg_rst_seq_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (output avs_address, output avs_read, input  avs_readdata);
  modport slave  (input  avs_address, input  avs_read, output avs_readdata);
endinterface

// File: rtl/usb_otg_rst_seq.sv
// Sequences the OTG controller reset: stretched assert, timed settle, ready.
// Latency: rst_req reaches the FSM one clk late (rq_q); outputs are registered.
// Backpressure: none; status reads are always accepted, data one clk later.
//
// Ports: clk, reset (async, active-high), rst_req (PIO request level),
//        avs (status slave), otg_rst_n (to controller), ready,
//        irq (only when USB_OTG_RST_IRQ_EN is defined).
// Optional feature macro: USB_OTG_RST_IRQ_EN adds a ready interrupt that is
// cleared by reading the status word.
module usb_otg_rst_seq
  import usb_otg_rst_pkg::*;
#(
  parameter int ASSERT_CYCLES = 2500,
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rst_req,
  usb_otg_rst_seq_if.slave   avs,
  output logic               otg_rst_n,
  output logic               ready
`ifdef USB_OTG_RST_IRQ_EN
  ,
  output logic               irq
`endif
);

  if (ASSERT_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("usb_otg_rst_seq: ASSERT_CYCLES and SETTLE_CYCLES must be >= 1");
  end
  if ((ASSERT_CYCLES - 1) >= (2 ** CNT_W) || (SETTLE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("usb_otg_rst_seq: CNT_W too narrow for the cycle counts");
  end

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [15:0]       rst_count, rst_count_nxt;
  logic              rq_q;
  logic              irq_bit;
  logic [31:0]       rd_word;

  // Next-state: the request restarts/stretches the assert phase wherever it
  // is seen; the settle phase is only completed with no request pending.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rst_count_nxt = rst_count;
    case (state)
      ST_ASSERT: begin
        if (rq_q) begin
          cnt_nxt = '0;
        end else if (cnt == ASSERT_LAST) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (rq_q) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
          if (rst_count != RST_COUNT_MAX) rst_count_nxt = rst_count + 16'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_READY: begin
        cnt_nxt = '0;
        if (rq_q) state_nxt = ST_ASSERT;
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_q      <= 1'b0;
      state     <= ST_ASSERT;
      cnt       <= '0;
      rst_count <= '0;
      otg_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      rq_q      <= rst_req;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_count <= rst_count_nxt;
      // Decoded from the next state so the pins change on the same edge as
      // the state register (otg_rst_n falls on the edge entering ASSERT).
      otg_rst_n <= (state_nxt != ST_ASSERT);
      ready     <= (state_nxt == ST_READY);
    end
  end

`ifdef USB_OTG_RST_IRQ_EN
  // Entry to ASSERT wins over everything; otherwise a set beats a read-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (state_nxt == ST_ASSERT && state != ST_ASSERT) begin
      irq <= 1'b0;
    end else if (state_nxt == ST_READY && state != ST_READY) begin
      irq <= 1'b1;
    end else if (avs.avs_read && avs.avs_address == ADDR_STATUS) begin
      irq <= 1'b0;
    end
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (avs.avs_address)
      ADDR_STATUS: begin
        rd_word[STAT_READY_BIT]                = ready;
        rd_word[STAT_STATE_MSB:STAT_STATE_LSB] = state;
        rd_word[STAT_RQ_BIT]                   = rq_q;
        rd_word[STAT_IRQ_BIT]                  = irq_bit;
      end
      ADDR_COUNT: rd_word[15:0]      = rst_count;
      ADDR_TIMER: rd_word[CNT_W-1:0] = cnt;
      default:    rd_word            = '0;
    endcase
  end

  // Read data holds between reads so a slow master can sample it late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs.avs_readdata <= '0;
    end else if (avs.avs_read) begin
      avs.avs_readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_usb_otg_rst_seq.sv
// Directed self-checking bench for usb_otg_rst_seq (ASSERT_CYCLES=4,
// SETTLE_CYCLES=6). Inputs are driven and outputs sampled 1 ns after the
// rising edge of clk.
module tb_usb_otg_rst_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_req = 1'b0;
  logic otg_rst_n;
  logic ready;
`ifdef USB_OTG_RST_IRQ_EN
  logic irq;
  localparam logic [31:0] STATUS_READY_IRQ = 32'h15;
`else
  localparam logic [31:0] STATUS_READY_IRQ = 32'h05;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  usb_otg_rst_seq_if avs_if ();

  usb_otg_rst_seq #(
    .ASSERT_CYCLES(4),
    .SETTLE_CYCLES(6),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rst_req(rst_req),
    .avs(avs_if),
    .otg_rst_n(otg_rst_n),
    .ready(ready)
`ifdef USB_OTG_RST_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic avs_rd(input logic [1:0] addr);
    avs_if.avs_address = addr;
    avs_if.avs_read = 1'b1;
    tick();
    avs_if.avs_read = 1'b0;
  endtask

  // One-cycle request from READY: rq_q sees it after edge 1, ASSERT entered at edge 2.
  task automatic pulse_req;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    int n;
    avs_if.avs_address = 2'd0;
    avs_if.avs_read = 1'b0;
    reset = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (otg_rst_n !== 1'b0 || ready !== 1'b0 || avs_if.avs_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_values: otg_rst_n=%b ready=%b readdata=%h, need 0 0 0",
               otg_rst_n, ready, avs_if.avs_readdata);
    end
    reset = 1'b0;
    n = 0;
    while (otg_rst_n !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL powerup_low_width: got %0d cycles, need 4", n);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL powerup_settle: got %0d cycles, need 6", n);
    end
    avs_rd(2'd1);
    tests_run++;
    if (avs_if.avs_readdata !== 32'd1) begin
      tests_failed++;
      $display("FAIL powerup_rst_count: got %h, need 00000001", avs_if.avs_readdata);
    end
    avs_rd(2'd3);
    tests_run++;
    if (avs_if.avs_readdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL addr3_zero: got %h, need 00000000", avs_if.avs_readdata);
    end
  endtask

  task automatic test_pulse;
    int n;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tests_run++;
    if (otg_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL pulse_not_early: otg_rst_n=%b, need 1", otg_rst_n);
    end
    tick();
    n = 0;
    while (otg_rst_n !== 1'b1 && n < 100) begin n++; tick(); end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL pulse_low_width: got %0d cycles, need 4", n);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL pulse_settle: got %0d cycles, need 6", n);
    end
    avs_rd(2'd1);
    tests_run++;
    if (avs_if.avs_readdata !== 32'd2) begin
      tests_failed++;
      $display("FAIL pulse_rst_count: got %h, need 00000002", avs_if.avs_readdata);
    end
  endtask

  // Request held for 20 edges (rq_q high at edges 1..20). The first high rq_q
  // cycle moves READY->ASSERT at edge 2, cnt stays 0 through edge 21, counts
  // 1..3 at edges 22..24, SETTLE at edge 25: low for 23 cycles.
  task automatic test_hold;
    int n;
    int bad_cnt;
    n = 0;
    bad_cnt = 0;
    rst_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      avs_rd(2'd2);
      tests_run++;
      if (avs_if.avs_readdata !== 32'd0) begin
        tests_failed++;
        $display("FAIL hold_cnt_zero[%0d]: got %h, need 00000000", i, avs_if.avs_readdata);
      end
      if (otg_rst_n === 1'b0) n++;
    end
    rst_req = 1'b0;
    while (n < 200) begin
      tick();
      if (otg_rst_n === 1'b1) break;
      n++;
    end
    tests_run++;
    if (n !== 23) begin
      tests_failed++;
      $display("FAIL hold_low_width: got %0d cycles, need 23", n);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL hold_settle: got %0d cycles, need 6", n);
    end
  endtask

  task automatic test_abort;
    int n;
    int saw_ready;
    pulse_req();
    n = 0;
    while (otg_rst_n !== 1'b1 && n < 100) begin n++; tick(); end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL abort_first_low: got %0d cycles, need 4", n);
    end
    repeat (3) tick();  // SETTLE, cnt now 3
    rst_req = 1'b1;
    avs_if.avs_address = 2'd2;
    avs_if.avs_read = 1'b1;
    tick();
    rst_req = 1'b0;
    avs_if.avs_read = 1'b0;
    tests_run++;
    if (avs_if.avs_readdata !== 32'd3 || otg_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_at_cnt3: readdata=%h otg_rst_n=%b, need 00000003 1",
               avs_if.avs_readdata, otg_rst_n);
    end
    tick();
    tests_run++;
    if (otg_rst_n !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_fall: otg_rst_n=%b ready=%b, need 0 0", otg_rst_n, ready);
    end
    n = 0;
    saw_ready = 0;
    while (otg_rst_n !== 1'b1 && n < 100) begin
      n++;
      tick();
      if (ready === 1'b1) saw_ready = 1;
    end
    tests_run++;
    if (n !== 4 || saw_ready !== 0) begin
      tests_failed++;
      $display("FAIL abort_restart_low: got %0d cycles ready_seen=%0d, need 4 0", n, saw_ready);
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL abort_restart_settle: got %0d cycles, need 6", n);
    end
    avs_rd(2'd1);
    tests_run++;
    if (avs_if.avs_readdata !== 32'd4) begin
      tests_failed++;
      $display("FAIL abort_rst_count: got %h, need 00000004", avs_if.avs_readdata);
    end
  endtask

  task automatic test_irq;
    int n;
    pulse_req();
`ifdef USB_OTG_RST_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_low_in_assert: got %b, need 0", irq);
    end
`endif
    n = 0;
    while (ready !== 1'b1 && n < 200) begin tick(); n++; end
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL irq_seq_to_ready: got %0d cycles, need 10", n);
    end
`ifdef USB_OTG_RST_IRQ_EN
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_with_ready: got %b, need 1", irq);
    end
`endif
    avs_rd(2'd1);
    tests_run++;
    if (avs_if.avs_readdata !== 32'd5) begin
      tests_failed++;
      $display("FAIL irq_rst_count: got %h, need 00000005", avs_if.avs_readdata);
    end
`ifdef USB_OTG_RST_IRQ_EN
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_kept_by_addr1: got %b, need 1", irq);
    end
`endif
    avs_rd(2'd0);
    tests_run++;
    if (avs_if.avs_readdata !== STATUS_READY_IRQ) begin
      tests_failed++;
      $display("FAIL status_word_ready: got %h, need %h", avs_if.avs_readdata, STATUS_READY_IRQ);
    end
`ifdef USB_OTG_RST_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_cleared_by_read: got %b, need 0", irq);
    end
`endif
    avs_rd(2'd0);
    tests_run++;
    if (avs_if.avs_readdata !== 32'h05) begin
      tests_failed++;
      $display("FAIL status_word_after_clear: got %h, need 00000005", avs_if.avs_readdata);
    end
  endtask

  task automatic test_async_reset;
    int n;
    pulse_req();
    n = 0;
    while (otg_rst_n !== 1'b1 && n < 100) begin n++; tick(); end
    tick();
    avs_rd(2'd1);  // still in SETTLE, leaves readdata non-zero
    tests_run++;
    if (otg_rst_n !== 1'b1 || ready !== 1'b0 || avs_if.avs_readdata !== 32'd5) begin
      tests_failed++;
      $display("FAIL pre_reset_settle: otg_rst_n=%b ready=%b readdata=%h, need 1 0 00000005",
               otg_rst_n, ready, avs_if.avs_readdata);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (otg_rst_n !== 1'b0 || ready !== 1'b0 || avs_if.avs_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: otg_rst_n=%b ready=%b readdata=%h, need 0 0 00000000",
               otg_rst_n, ready, avs_if.avs_readdata);
    end
`ifdef USB_OTG_RST_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_irq: got %b, need 0", irq);
    end
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_hold();
    test_abort();
    test_irq();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
